// File: rtl/pp_accum_bank_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : pp_accum_bank_pkg                                              |
// | Purpose  : Shared definitions for the partial-product accumulator bank:   |
// |            FSM state encoding and width helper functions.                 |
// | Ports    : none (package)                                                 |
// | Revision : 1.0 - initial parametrised release                             |
// +---------------------------------------------------------------------------+
package pp_accum_bank_pkg;

  // Encoding is fixed; 2'd3 is unreachable and treated as a fault that
  // recovers to FILL with reset values.
  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } pp_state_e;

  // Width of the occupancy counter: must represent 0..depth inclusive.
  function automatic int pp_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Width of the accumulate index: addresses entries 0..depth-1.
  function automatic int pp_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pp_accum_bank_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : pp_accum_bank_if                                               |
// | Purpose  : Input (partial product) and output (product) handshakes of    |
// |            the accumulator bank.                                          |
// | Ports    : in_valid/in_ready/in_data  - partial-product stream            |
// |            out_valid/out_ready/out_data - product stream                  |
// |            modport master : producer/consumer side (drives in_*, ready)   |
// |            modport slave  : the bank itself                               |
// | Revision : 1.0 - initial parametrised release                             |
// +---------------------------------------------------------------------------+
interface pp_accum_bank_if #(
  parameter int WIDTH = 15,
  parameter int OUT_W = 23
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/pp_accum_bank_entry_reg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : pp_entry_reg                                                   |
// | Purpose  : One WIDTH-bit storage entry of the partial-product bank.       |
// | Ports    : clk  - rising-edge clock                                       |
// |            rst  - asynchronous active-low reset (entry -> 0)              |
// |            i_en - load enable                                             |
// |            i_d  - load data                                               |
// |            o_q  - stored value                                            |
// | Revision : 1.0 - initial parametrised release                             |
// +---------------------------------------------------------------------------+
module pp_entry_reg #(
  parameter int WIDTH = 15
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_en,
  input  wire logic [WIDTH-1:0] i_d,
  output logic      [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else if (i_en) begin
      q_q <= i_d;
    end
  end

  assign o_q = q_q;

endmodule
`default_nettype wire

// File: rtl/pp_accum_bank.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : pp_accum_bank                                                  |
// | Purpose  : Buffers DEPTH signed partial products, then shift-adds them    |
// |            (entry i weighted 2^i) into one signed OUT_W-bit product.      |
// | Ports    : clk   - rising-edge clock                                      |
// |            rst   - asynchronous active-low reset                          |
// |            clear - synchronous flush                                      |
// |            bus   - in/out valid-ready handshakes (slave modport)          |
// |            busy  - high while accumulating or holding a product           |
// |            count - number of stored entries, 0..DEPTH                     |
// | Revision : 1.0 - initial parametrised release                             |
// +---------------------------------------------------------------------------+
module pp_accum_bank
  import pp_accum_bank_pkg::*;
#(
  parameter int WIDTH = 15,
  parameter int DEPTH = 8,
  parameter int OUT_W = WIDTH + DEPTH,
  parameter int CNT_W = pp_cnt_w(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clear,
  pp_accum_bank_if.slave        bus,
  output logic                  busy,
  output logic      [CNT_W-1:0] count
);

  localparam int IDX_W = pp_idx_w(DEPTH);

  pp_state_e        state_q,     state_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [IDX_W-1:0] k_q,         k_d;
  logic [OUT_W-1:0] acc_q,       acc_d;
  logic [OUT_W-1:0] out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q,  in_ready_d;
  logic             busy_q,      busy_d;

  logic [WIDTH-1:0] entry_q [DEPTH];
  logic [DEPTH-1:0] entry_we;
  logic [WIDTH-1:0] entry_din;
  logic [WIDTH-1:0] entry_sel;
  logic [OUT_W-1:0] addend;
  logic             flush;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    pp_entry_reg #(
      .WIDTH (WIDTH)
    ) u_entry (
      .clk  (clk),
      .rst  (rst),
      .i_en (entry_we[gi]),
      .i_d  (entry_din),
      .o_q  (entry_q[gi])
    );
  end

  // Sign-extend the selected entry to full width, then weight it by 2^k.
  assign entry_sel = entry_q[k_q];
  assign addend    = {{(OUT_W-WIDTH){entry_sel[WIDTH-1]}}, entry_sel} << k_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    k_d         = k_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    entry_we    = '0;
    entry_din   = bus.in_data;
    flush       = 1'b0;

    if (clear) begin
      flush = 1'b1;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (bus.in_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
              entry_we[i] = (count_q == CNT_W'(i));
            end
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_W'(DEPTH - 1)) begin
              state_d    = ST_ACCUM;
              acc_d      = '0;
              k_d        = '0;
              in_ready_d = 1'b0;
              busy_d     = 1'b1;
            end
          end
        end
        ST_ACCUM: begin
          acc_d = acc_q + addend;
          k_d   = k_q + IDX_W'(1);
          if (k_q == IDX_W'(DEPTH - 1)) begin
            state_d     = ST_DONE;
            out_data_d  = acc_q + addend;
            out_valid_d = 1'b1;
          end
        end
        ST_DONE: begin
          // Entries are left as-is; the next fill overwrites them.
          if (bus.out_ready) begin
            state_d     = ST_FILL;
            count_d     = '0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
          end
        end
        default: begin
          flush = 1'b1;
        end
      endcase
    end

    // Flush reproduces the complete reset state, including zeroed entries.
    if (flush) begin
      state_d     = ST_FILL;
      count_d     = '0;
      k_d         = '0;
      acc_d       = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
      busy_d      = 1'b0;
      entry_we    = '1;
      entry_din   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FILL;
      count_q     <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = busy_q;
  assign count         = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pp_accum_bank.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_pp_accum_bank                                               |
// | Purpose  : Scoreboard bench for pp_accum_bank (WIDTH=15, DEPTH=8).        |
// |            The driver pushes each expected product (sum of value*2^i)     |
// |            and its last-write edge; a monitor pops on out_valid.          |
// | Ports    : none                                                           |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module tb_pp_accum_bank;

  localparam int WIDTH = 15;
  localparam int DEPTH = 8;
  localparam int OUT_W = WIDTH + DEPTH;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             clear;
  logic             busy;
  logic [CNT_W-1:0] count;

  pp_accum_bank_if #(.WIDTH(WIDTH), .OUT_W(OUT_W)) bus ();

  pp_accum_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus),
    .busy  (busy),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int value;
    int t_last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares each new product against the scoreboard and checks
  // that a held product does not change while waiting for out_ready.
  initial begin : monitor
    bit   pv;
    int   pd;
    int   act;
    exp_t e;
    pv = 1'b0;
    pd = 0;
    forever begin
      @(negedge clk);
      if (rst && bus.out_valid) begin
        act = int'($signed(bus.out_data));
        if (!pv) begin
          if (exp_q.size() == 0) begin
            check("unexpected_product", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("product", act, e.value);
            check("latency", cyc - e.t_last, DEPTH);
          end
        end else begin
          check("hold_stable", act, pd);
        end
        pd = act;
      end
      pv = rst && bus.out_valid;
    end
  end

  // Present one value and wait for it to be accepted; t returns the edge index.
  task automatic send(input int val, output int t);
    int budget;
    logic [WIDTH-1:0] v;
    v = val[WIDTH-1:0];
    budget = 0;
    bus.in_data  = v;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      budget++;
      if (budget > 50) begin
        $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "input handshake never completed");
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    t = cyc;
  endtask

  task automatic fill(input int vals[DEPTH], input bit gapped, input bit push);
    int t;
    int sum;
    sum = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (gapped) begin
        repeat (i == 0 ? 0 : 2) begin
          @(posedge clk);
          #1;
        end
        check("gap_count", count, i);
      end
      send(vals[i], t);
      sum += vals[i] * (1 << i);
      check("fill_count", count, i + 1);
    end
    if (push) exp_q.push_back('{sum, t});
    check("accum_in_ready", bus.in_ready, 0);
    check("accum_busy", busy, 1);
  endtask

  task automatic wait_valid();
    int budget;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
      // Upstream pokes while the bank is busy must be ignored.
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = WIDTH'($urandom);
    end while (!bus.out_valid && budget < 4 * DEPTH);
    check("valid_timeout", bus.out_valid, 1);
  endtask

  task automatic drain(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_count", count, DEPTH);
      check("hold_in_ready", bus.in_ready, 0);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = WIDTH'($urandom);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("drain_count", count, 0);
    check("drain_in_ready", bus.in_ready, 1);
    check("drain_valid", bus.out_valid, 0);
    check("drain_busy", busy, 0);
  endtask

  task automatic run_op(input int vals[DEPTH], input bit gapped, input int hold);
    fill(vals, gapped, 1'b1);
    wait_valid();
    drain(hold);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_data"}, bus.out_data, 0);
  endtask

  // mode 0: async reset in ACCUM, 1: clear in ACCUM, 2: clear in DONE
  task automatic abort_op(input int mode, input int vals[DEPTH]);
    fill(vals, 1'b0, mode == 2);
    if (mode == 2) begin
      wait_valid();
      @(negedge clk);
      bus.in_valid = 1'b0;
    end else begin
      repeat (2) @(posedge clk);
    end
    if (mode == 0) begin
      #2;
      rst = 1'b0;
      #1;
      check_idle("rst_abort");
      @(negedge clk);
      rst = 1'b1;
    end else begin
      @(negedge clk);
      clear          = 1'b1;
      bus.in_valid   = 1'b1;
      bus.out_ready  = 1'b1;
      @(posedge clk);
      #1;
      clear         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check_idle("clear_abort");
    end
    // No product may surface from the aborted operation.
    repeat (DEPTH + 2) @(posedge clk);
    #1;
    check("abort_no_product", bus.out_valid, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "simulation watchdog expired");
  end

  initial begin : driver
    int v[DEPTH];
    rst           = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle("post_reset");

    v = '{3, 0, 3, 0, 0, 0, 0, 0};
    run_op(v, 1'b0, 0);                       // 15
    v = '{-3, 0, -3, 0, 0, 0, 0, 0};
    run_op(v, 1'b0, 2);                       // -15
    v = '{5, -7, 100, 0, -1, 2, 9, -16384};
    run_op(v, 1'b0, 10);                      // backpressure
    v = '{1, 2, 3, 4, 5, 6, 7, 8};
    run_op(v, 1'b1, 1);                       // gapped, 1793
    v = '{-16384, -16384, -16384, -16384, -16384, -16384, -16384, -16384};
    run_op(v, 1'b0, 0);                       // -4177920
    v = '{16383, 16383, 16383, 16383, 16383, 16383, 16383, 16383};
    run_op(v, 1'b0, 0);                       // positive extreme

    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < DEPTH; i++) v[i] = int'($urandom_range(0, 32767)) - 16384;
      abort_op(m, v);
      for (int i = 0; i < DEPTH; i++) v[i] = int'($urandom_range(0, 32767)) - 16384;
      run_op(v, 1'b0, 0);
    end

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < DEPTH; i++) v[i] = int'($urandom_range(0, 32767)) - 16384;
      run_op(v, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
